// File: rtl/fft8_pkg.sv
// Shared types and constants for the fft8 result-streaming slice.
package fft8_pkg;

   // One complex FFT result word: real half in the upper 16 bits, imaginary in the lower.
   typedef struct packed {
      logic [15:0] re;
      logic [15:0] im;
   } cplx16_t;

   localparam int FP16_EXP_MAX = 31;
   localparam int N_POINTS     = 8;
   localparam int IDX_W        = 3;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      SEND
   } state_t;

endpackage

// File: rtl/fft8_stream_out_if.sv
// Valid/ready stream carrying one processed FFT bin per beat, with its index and a frame-end flag.
interface fft8_stream_out_if;
   import fft8_pkg::*;

   logic             m_valid;
   logic             m_ready;
   cplx16_t          m_data;
   logic [IDX_W-1:0] m_index;
   logic             m_last;

   modport master (
      output m_valid,
      output m_data,
      output m_index,
      output m_last,
      input  m_ready
   );

   modport slave (
      input  m_valid,
      input  m_data,
      input  m_index,
      input  m_last,
      output m_ready
   );

endinterface

// File: rtl/fp16_scale_conj.sv
// Combinational fp16 post-processing for one half-word: optional sign flip, then
// division by 2^SCALE_SHIFT done purely on the exponent field.
module fp16_scale_conj
   import fft8_pkg::*;
#(
   parameter int SCALE_SHIFT = 0,
   parameter bit NEG_SIGN    = 1'b0
) (
   input  logic [15:0] din,
   output logic [15:0] dout
);

   // Exponent-only scaling: inf/NaN keep their encoding, anything that would
   // underflow (including incoming zero/subnormal) collapses to a signed zero.
   function automatic logic [15:0] scale_half(input logic [15:0] h);
      logic       s;
      logic [4:0] e;
      logic [9:0] f;
      logic [15:0] r;
      s = h[15] ^ NEG_SIGN;
      e = h[14:10];
      f = h[9:0];
      if (SCALE_SHIFT == 0 || e == 5'(FP16_EXP_MAX)) begin
         r = {s, e, f};
      end else if (e == 5'd0 || e <= 5'(SCALE_SHIFT)) begin
         r = {s, 15'd0};
      end else begin
         r = {s, e - 5'(SCALE_SHIFT), f};
      end
      return r;
   endfunction

   assign dout = scale_half(din);

endmodule

// File: rtl/fft8_stream_out.sv
// Waits a fixed latency after launch, captures the eight fft8_fp result words
// (optionally conjugated and scaled) and streams them out in bin order 0..7.
module fft8_stream_out
   import fft8_pkg::*;
#(
   parameter int FFT_LATENCY = 1,
   parameter int SCALE_SHIFT = 0,
   parameter int CONJ        = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  cplx16_t           fft_out1,
   input  cplx16_t           fft_out2,
   input  cplx16_t           fft_out3,
   input  cplx16_t           fft_out4,
   input  cplx16_t           fft_out5,
   input  cplx16_t           fft_out6,
   input  cplx16_t           fft_out7,
   input  cplx16_t           fft_out8,
   fft8_stream_out_if.master m,
   output logic              busy,
   output logic              drop
);

   localparam int               CNT_W    = (FFT_LATENCY < 1) ? 1 : $clog2(FFT_LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FFT_LATENCY);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_POINTS - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             capture;
   logic             handshake;

   cplx16_t          raw_w   [N_POINTS];
   logic [15:0]      proc_re [N_POINTS];
   logic [15:0]      proc_im [N_POINTS];
   cplx16_t          frame_q [N_POINTS];

   cplx16_t          data_q;
   logic [IDX_W-1:0] idx_q;
   logic             last_q;

   assign raw_w[0] = fft_out1;
   assign raw_w[1] = fft_out2;
   assign raw_w[2] = fft_out3;
   assign raw_w[3] = fft_out4;
   assign raw_w[4] = fft_out5;
   assign raw_w[5] = fft_out6;
   assign raw_w[6] = fft_out7;
   assign raw_w[7] = fft_out8;

   // Conjugation only ever touches the imaginary half; scaling applies to both.
   for (genvar i = 0; i < N_POINTS; i++) begin : g_word
      fp16_scale_conj #(
         .SCALE_SHIFT (SCALE_SHIFT),
         .NEG_SIGN    (1'b0)
      ) u_re (
         .din  (raw_w[i].re),
         .dout (proc_re[i])
      );

      fp16_scale_conj #(
         .SCALE_SHIFT (SCALE_SHIFT),
         .NEG_SIGN    (CONJ != 0)
      ) u_im (
         .din  (raw_w[i].im),
         .dout (proc_im[i])
      );
   end

   assign handshake = (state == SEND) && m.m_ready;

   // State and latency counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state logic: count down the fft8_fp latency, capture, then drain eight beats.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      capture   = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = WAIT;
               cnt_nxt   = CNT_INIT;
            end
         end
         WAIT: begin
            if (cnt == '0) begin
               capture   = 1'b1;
               state_nxt = SEND;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         SEND: begin
            if (handshake && idx_q == IDX_LAST) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Capture buffer and registered stream outputs; the output word only advances
   // on a handshake so it holds steady while the sink stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_POINTS; i++) begin
            frame_q[i] <= '0;
         end
         data_q <= '0;
         idx_q  <= '0;
         last_q <= 1'b0;
      end else if (capture) begin
         for (int i = 0; i < N_POINTS; i++) begin
            frame_q[i] <= {proc_re[i], proc_im[i]};
         end
         data_q <= {proc_re[0], proc_im[0]};
         idx_q  <= '0;
         last_q <= 1'b0;
      end else if (handshake) begin
         if (idx_q == IDX_LAST) begin
            idx_q  <= '0;
            last_q <= 1'b0;
         end else begin
            idx_q  <= idx_q + IDX_W'(1);
            data_q <= frame_q[idx_q + IDX_W'(1)];
            last_q <= ((idx_q + IDX_W'(1)) == IDX_LAST);
         end
      end
   end

   assign m.m_valid = (state == SEND);
   assign m.m_data  = data_q;
   assign m.m_index = idx_q;
   assign m.m_last  = last_q;

   // A start seen in any non-idle cycle (including the final beat) is refused.
   assign busy = (state != IDLE);
   assign drop = start && busy;

endmodule

// File: tb/tb_fft8_stream_out.sv
// Scoreboard bench for fft8_stream_out: three instances with different
// latency / conjugate / scale settings, random data and random backpressure.
module tb_fft8_stream_out;

   localparam int LAT0 = 1, K0 = 0, CJ0 = 0;
   localparam int LAT1 = 2, K1 = 3, CJ1 = 1;
   localparam int LAT2 = 0, K2 = 0, CJ2 = 0;

   logic        clk = 1'b0;
   logic [2:0]  rst_s = 3'b000;
   logic [2:0]  start_s = 3'b000;
   logic [31:0] fin [8];
   logic        busy_a, drop_a, busy_b, drop_b, busy_c, drop_c;
   int          rmode [3];

   int n_checks = 0;
   int n_fail   = 0;

   logic [35:0] expq [3][$];
   bit          prev_stall [3];
   bit          use_spec = 1'b0;
   logic [31:0] spec_exp [3];

   fft8_stream_out_if ifa ();
   fft8_stream_out_if ifb ();
   fft8_stream_out_if ifc ();

   always #5 clk = ~clk;

   fft8_stream_out #(.FFT_LATENCY(LAT0), .SCALE_SHIFT(K0), .CONJ(CJ0)) dut_a (
      .clk(clk), .rst_n(rst_s[0]), .start(start_s[0]),
      .fft_out1(fin[0]), .fft_out2(fin[1]), .fft_out3(fin[2]), .fft_out4(fin[3]),
      .fft_out5(fin[4]), .fft_out6(fin[5]), .fft_out7(fin[6]), .fft_out8(fin[7]),
      .m(ifa), .busy(busy_a), .drop(drop_a));

   fft8_stream_out #(.FFT_LATENCY(LAT1), .SCALE_SHIFT(K1), .CONJ(CJ1)) dut_b (
      .clk(clk), .rst_n(rst_s[1]), .start(start_s[1]),
      .fft_out1(fin[0]), .fft_out2(fin[1]), .fft_out3(fin[2]), .fft_out4(fin[3]),
      .fft_out5(fin[4]), .fft_out6(fin[5]), .fft_out7(fin[6]), .fft_out8(fin[7]),
      .m(ifb), .busy(busy_b), .drop(drop_b));

   fft8_stream_out #(.FFT_LATENCY(LAT2), .SCALE_SHIFT(K2), .CONJ(CJ2)) dut_c (
      .clk(clk), .rst_n(rst_s[2]), .start(start_s[2]),
      .fft_out1(fin[0]), .fft_out2(fin[1]), .fft_out3(fin[2]), .fft_out4(fin[3]),
      .fft_out5(fin[4]), .fft_out6(fin[5]), .fft_out7(fin[6]), .fft_out8(fin[7]),
      .m(ifc), .busy(busy_c), .drop(drop_c));

   function automatic int lat_of(input int d);
      return (d == 0) ? LAT0 : (d == 1) ? LAT1 : LAT2;
   endfunction
   function automatic int k_of(input int d);
      return (d == 0) ? K0 : (d == 1) ? K1 : K2;
   endfunction
   function automatic bit cj_of(input int d);
      return (d == 0) ? (CJ0 != 0) : (d == 1) ? (CJ1 != 0) : (CJ2 != 0);
   endfunction

   // {valid, ready, last, index[2:0], busy, drop, data[31:0]}
   function automatic logic [39:0] outs(input int d);
      case (d)
         0: return {ifa.m_valid, ifa.m_ready, ifa.m_last, ifa.m_index, busy_a, drop_a, 32'(ifa.m_data)};
         1: return {ifb.m_valid, ifb.m_ready, ifb.m_last, ifb.m_index, busy_b, drop_b, 32'(ifb.m_data)};
         default: return {ifc.m_valid, ifc.m_ready, ifc.m_last, ifc.m_index, busy_c, drop_c, 32'(ifc.m_data)};
      endcase
   endfunction

   // Reference: value divided by 2^k through the exponent; underflow gives signed zero.
   function automatic logic [15:0] ref_half(input logic [15:0] h, input bit neg, input int k);
      logic s;
      int   e;
      s = h[15] ^ neg;
      e = int'(h[14:10]);
      if (k == 0 || e == 31) return {s, h[14:0]};
      if (e - k <= 0) return {s, 15'd0};
      return {s, 5'(e - k), h[9:0]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h at %0t", nm, act, want, $time);
      end
   endtask

   task automatic mon(input int d);
      logic [39:0] o;
      logic [35:0] e;
      o = outs(d);
      if (!rst_s[d]) begin
         chk($sformatf("rst_outs_d%0d", d), {25'd0, o[39], o[37:32]}, 32'd0);
         chk($sformatf("rst_data_d%0d", d), o[31:0], 32'd0);
         prev_stall[d] = 1'b0;
      end else begin
         if (prev_stall[d]) chk($sformatf("valid_hold_d%0d", d), 32'(o[39]), 32'd1);
         if (o[39]) begin
            if (expq[d].size() == 0) begin
               chk($sformatf("unexpected_beat_d%0d", d), 32'(o[39]), 32'd0);
            end else begin
               e = expq[d][0];
               chk($sformatf("data_d%0d", d), o[31:0], e[31:0]);
               chk($sformatf("index_d%0d", d), 32'(o[36:34]), 32'(e[34:32]));
               chk($sformatf("last_d%0d", d), 32'(o[37]), 32'(e[35]));
               if (o[38]) void'(expq[d].pop_front());
            end
         end
         prev_stall[d] = o[39] && !o[38];
      end
   endtask

   // Monitor: compare every presented beat against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) mon(d);
      end
   end

   // Ready driver: mode 0 always ready, 1 = pattern 1,0,0,1, 2 = random.
   initial begin
      int pc;
      logic [2:0] r;
      pc = 0;
      rmode[0] = 0; rmode[1] = 0; rmode[2] = 0;
      ifa.m_ready = 1'b1; ifb.m_ready = 1'b1; ifc.m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         for (int d = 0; d < 3; d++) begin
            case (rmode[d])
               0: r[d] = 1'b1;
               1: r[d] = (pc % 4 == 0) || (pc % 4 == 3);
               default: r[d] = 1'($urandom_range(0, 1));
            endcase
         end
         pc++;
         ifa.m_ready = r[0]; ifb.m_ready = r[1]; ifc.m_ready = r[2];
      end
   end

   // Called just after a posedge; returns in the following cycle (or at the first-beat negedge).
   task automatic start_frame(input int d, input bit chk_lat);
      logic [31:0] w;
      for (int i = 0; i < 8; i++) begin
         w = {ref_half(fin[i][31:16], 1'b0, k_of(d)), ref_half(fin[i][15:0], cj_of(d), k_of(d))};
         if (use_spec && i < 3) w = spec_exp[i];
         expq[d].push_back({(i == 7), 3'(i), w});
      end
      start_s[d] = 1'b1;
      @(negedge clk);
      chk("drop_on_start", 32'(outs(d)[32]), 32'd0);
      chk("busy_on_start", 32'(outs(d)[33]), 32'd0);
      @(posedge clk); #1;
      start_s[d] = 1'b0;
      if (chk_lat) begin
         repeat (lat_of(d) + 1) begin
            @(negedge clk);
            chk("latency_valid_low", 32'(outs(d)[39]), 32'd0);
         end
         @(negedge clk);
         chk("latency_valid_rise", 32'(outs(d)[39]), 32'd1);
      end
   endtask

   task automatic wait_drain(input int d);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (expq[d].size() == 0 && !outs(d)[39]) done = 1'b1;
      end
      chk("drain_complete", 32'(done), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic rand_fin();
      for (int i = 0; i < 8; i++) fin[i] = $urandom;
   endtask

   initial begin
      bit got;
      for (int i = 0; i < 8; i++) fin[i] = '0;
      spec_exp[0] = 32'h4100_B400;
      spec_exp[1] = 32'h7C00_7E00;
      spec_exp[2] = 32'h0000_8000;
      repeat (3) @(posedge clk);
      #1 rst_s = 3'b111;
      @(posedge clk); #1;

      // Default frame: passthrough, 8 consecutive beats, busy falls afterwards.
      fin[0] = 32'h4D00_0000; fin[1] = 32'hC000_C0D7; fin[2] = 32'h0; fin[3] = 32'h8000_3CD7;
      fin[4] = 32'h0;         fin[5] = 32'h8000_BCD7; fin[6] = 32'h0; fin[7] = 32'hC000_40D7;
      start_frame(0, 1'b1);
      for (int b = 1; b < 8; b++) begin
         @(negedge clk);
         chk("consecutive_beat", 32'(ifa.m_valid), 32'd1);
      end
      @(negedge clk);
      chk("valid_after_frame", 32'(ifa.m_valid), 32'd0);
      chk("busy_after_frame", 32'(busy_a), 32'd0);
      @(posedge clk); #1;

      // Backpressure pattern 1,0,0,1 with random data.
      rmode[0] = 1;
      repeat (2) begin
         rand_fin();
         start_frame(0, 1'b1);
         wait_drain(0);
      end
      rmode[0] = 0;

      // Conjugate + scale: given words, then random frames under random backpressure.
      rmode[1] = 2;
      rand_fin();
      fin[0] = 32'h4D00_4000; fin[1] = 32'h7C00_FE00; fin[2] = 32'h0C00_0001;
      use_spec = 1'b1;
      start_frame(1, 1'b1);
      use_spec = 1'b0;
      wait_drain(1);
      repeat (3) begin
         rand_fin();
         start_frame(1, 1'b1);
         wait_drain(1);
      end
      rmode[1] = 0;

      // Starts during WAIT, beat 3 and the final beat are dropped; no second frame.
      rand_fin();
      start_frame(0, 1'b0);
      start_s[0] = 1'b1;
      @(negedge clk);
      chk("drop_in_wait", 32'(drop_a), 32'd1);
      @(posedge clk); #1;
      start_s[0] = 1'b0;
      @(negedge clk);
      chk("drop_single_pulse", 32'(drop_a), 32'd0);
      @(posedge clk); #1;
      repeat (2) @(posedge clk);
      #1 start_s[0] = 1'b1;
      @(negedge clk);
      chk("drop_in_send", 32'(drop_a), 32'd1);
      chk("beat3_index", 32'(ifa.m_index), 32'd2);
      @(posedge clk); #1;
      start_s[0] = 1'b0;
      @(negedge clk);
      chk("drop_single_pulse2", 32'(drop_a), 32'd0);
      repeat (4) @(posedge clk);
      #1 start_s[0] = 1'b1;
      @(negedge clk);
      chk("drop_on_last_beat", 32'(drop_a), 32'd1);
      chk("last_on_drop_beat", 32'(ifa.m_last), 32'd1);
      @(posedge clk); #1;
      start_s[0] = 1'b0;
      @(negedge clk);
      chk("idle_after_dropped_starts", 32'(busy_a), 32'd0);
      repeat (10) @(posedge clk);
      #1;
      wait_drain(0);

      // Asynchronous reset during beat 5 discards the frame.
      rand_fin();
      start_frame(0, 1'b0);
      repeat (6) @(posedge clk);
      #1;
      rst_s[0] = 1'b0;
      expq[0].delete();
      @(negedge clk);
      chk("reset_valid_low", 32'(ifa.m_valid), 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_s[0] = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      rand_fin();
      start_frame(0, 1'b1);
      wait_drain(0);

      // Zero latency, back-to-back frames right after the last handshake.
      rand_fin();
      start_frame(2, 1'b1);
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (ifc.m_valid && ifc.m_ready && ifc.m_last) got = 1'b1;
      end
      chk("b2b_last_seen", 32'(got), 32'd1);
      @(posedge clk); #1;
      rand_fin();
      start_frame(2, 1'b1);
      wait_drain(2);
      rmode[2] = 2;
      rand_fin();
      start_frame(2, 1'b1);
      wait_drain(2);

      for (int d = 0; d < 3; d++) chk("queue_empty_at_end", 32'(expq[d].size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
